// File: rtl/mem_stage.sv
// +--------------------------------------------------------------------------+
// | mem_stage: RISC-V MEM pipeline stage - dmem handshake, load align/extend |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;
  typedef struct packed {
    logic       is_load;
    logic       is_store;
    logic       is_ecall;
    logic [4:0] rd;
    logic       en_rd;
    logic [2:0] funct3;
  } decoded_inst_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  decoded_inst_t in_inst,
  input  logic          in_is_bubble,
  input  logic [63:0]   in_alu_result,
  input  logic [63:0]   in_store_data,
  input  logic          wb_stall,
  output logic          dmem_req,
  output logic [63:0]   dmem_addr,
  output logic          dmem_we,
  output logic [63:0]   dmem_wdata,
  output logic [7:0]    dmem_wstrb,
  input  logic          dmem_gnt,
  input  logic          dmem_rvalid,
  input  logic [63:0]   dmem_rdata,
  output logic          mem_stall,
  output logic          misaligned,
  output decoded_inst_t wb_inst,
  output logic          wb_is_bubble,
  output logic [63:0]   wb_alu_result,
  output logic [63:0]   wb_mem_result
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [63:0]   hold_q;
  logic          misaligned_q;
  decoded_inst_t wb_inst_q, wb_inst_d;
  logic          wb_bub_q, wb_bub_d;
  logic [63:0]   wb_alu_q, wb_alu_d;
  logic [63:0]   wb_mem_q, wb_mem_d;

  logic [2:0]  offset;
  logic [1:0]  size;
  logic        memop;
  logic        aligned;
  logic        completing;
  logic        capture;
  logic        sgn;
  logic [63:0] load_src;
  logic [63:0] lane;
  logic [63:0] ext;
  logic [7:0]  bmask;

  assign offset  = in_alu_result[2:0];
  assign size    = in_inst.funct3[1:0];
  assign sgn     = ~in_inst.funct3[2];
  assign memop   = !in_is_bubble && (in_inst.is_load || in_inst.is_store);

  always_comb begin
    aligned = 1'b1;
    bmask   = 8'h01;
    unique case (size)
      2'd0: begin aligned = 1'b1;               bmask = 8'h01; end
      2'd1: begin aligned = (offset[0] == 1'b0);   bmask = 8'h03; end
      2'd2: begin aligned = (offset[1:0] == 2'b00); bmask = 8'h0F; end
      2'd3: begin aligned = (offset == 3'b000);    bmask = 8'hFF; end
      default: ;
    endcase
  end

  assign dmem_addr  = {in_alu_result[63:3], 3'b000};
  assign dmem_we    = in_inst.is_store;
  assign dmem_wdata = in_store_data << {offset, 3'b000};
  assign dmem_wstrb = bmask << offset;

  // A response parked in HOLD is replayed from the hold register.
  assign load_src = (state_q == S_HOLD) ? hold_q : dmem_rdata;
  assign lane     = load_src >> {offset, 3'b000};

  always_comb begin
    ext = lane;
    unique case (size)
      2'd0: ext = {{56{sgn & lane[7]}},  lane[7:0]};
      2'd1: ext = {{48{sgn & lane[15]}}, lane[15:0]};
      2'd2: ext = {{32{sgn & lane[31]}}, lane[31:0]};
      2'd3: ext = lane;
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    dmem_req   = 1'b0;
    completing = 1'b0;
    capture    = 1'b0;
    unique case (state_q)
      S_IDLE: if (memop && aligned && !wb_stall) begin
        dmem_req = 1'b1;
        state_d  = dmem_gnt ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) state_d = S_WAIT;
      end
      S_WAIT: if (dmem_rvalid) begin
        if (!wb_stall) begin
          completing = 1'b1;
          state_d    = S_IDLE;
        end else begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (!wb_stall) begin
        completing = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_stall = wb_stall || (memop && aligned && !completing);

  always_comb begin
    wb_inst_d = wb_inst_q;
    wb_bub_d  = wb_bub_q;
    wb_alu_d  = wb_alu_q;
    wb_mem_d  = wb_mem_q;
    if (!wb_stall) begin
      wb_inst_d = in_inst;
      wb_alu_d  = in_alu_result;
      wb_mem_d  = 64'h0;
      if (completing) begin
        wb_bub_d = 1'b0;
        wb_mem_d = in_inst.is_store ? 64'h0 : ext;
      end else if (memop) begin
        wb_bub_d = 1'b1;
      end else begin
        wb_bub_d = in_is_bubble;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= 64'h0;
      misaligned_q <= 1'b0;
      wb_inst_q    <= '0;
      wb_bub_q     <= 1'b1;
      wb_alu_q     <= 64'h0;
      wb_mem_q     <= 64'h0;
    end else begin
      state_q      <= state_d;
      if (capture) hold_q <= dmem_rdata;
      misaligned_q <= misaligned_q | (memop && !aligned);
      wb_inst_q    <= wb_inst_d;
      wb_bub_q     <= wb_bub_d;
      wb_alu_q     <= wb_alu_d;
      wb_mem_q     <= wb_mem_d;
    end
  end

  assign misaligned    = misaligned_q;
  assign wb_inst       = wb_inst_q;
  assign wb_is_bubble  = wb_bub_q;
  assign wb_alu_result = wb_alu_q;
  assign wb_mem_result = wb_mem_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +--------------------------------------------------------------------------+
// | tb_mem_stage: directed scoreboard bench for mem_stage                    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  decoded_inst_t in_inst;
  logic          in_is_bubble;
  logic [63:0]   in_alu_result;
  logic [63:0]   in_store_data;
  logic          wb_stall;
  logic          dmem_req;
  logic [63:0]   dmem_addr;
  logic          dmem_we;
  logic [63:0]   dmem_wdata;
  logic [7:0]    dmem_wstrb;
  logic          dmem_gnt;
  logic          dmem_rvalid;
  logic [63:0]   dmem_rdata;
  logic          mem_stall;
  logic          misaligned;
  decoded_inst_t wb_inst;
  logic          wb_is_bubble;
  logic [63:0]   wb_alu_result;
  logic [63:0]   wb_mem_result;

  mem_stage dut (
    .clk(clk), .reset(reset), .in_inst(in_inst), .in_is_bubble(in_is_bubble),
    .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .wb_stall(wb_stall), .dmem_req(dmem_req), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .misaligned(misaligned), .wb_inst(wb_inst),
    .wb_is_bubble(wb_is_bubble), .wb_alu_result(wb_alu_result),
    .wb_mem_result(wb_mem_result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Expected MEM->WB register contents; full=0 means only the bubble flag matters.
  typedef struct {
    logic        bub;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [4:0]  rd;
    bit          full;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_wb(input string tag);
    exp_t e;
    n_checks++;
    assert (sb.size() != 0) else begin
      n_err++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_bub"}, 64'(wb_is_bubble), 64'(e.bub));
      if (e.full) begin
        chk({tag, "_alu"}, wb_alu_result, e.alu);
        chk({tag, "_mem"}, wb_mem_result, e.mem);
        chk({tag, "_rd"},  64'(wb_inst.rd), 64'(e.rd));
      end
    end
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [4:0] rd, input logic bub,
                       input logic [63:0] alu, input logic [63:0] sd);
    in_inst          = '0;
    in_inst.is_load  = ld;
    in_inst.is_store = st;
    in_inst.funct3   = f3;
    in_inst.rd       = rd;
    in_inst.en_rd    = ld;
    in_is_bubble     = bub;
    in_alu_result    = alu;
    in_store_data    = sd;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'd0, 5'd0, 1'b1, 64'h0, 64'h0);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_bub"},   64'(wb_is_bubble), 64'h1);
    chk({tag, "_alu"},   wb_alu_result, 64'h0);
    chk({tag, "_mem"},   wb_mem_result, 64'h0);
    chk({tag, "_inst"},  64'(wb_inst), 64'h0);
    chk({tag, "_mis"},   64'(misaligned), 64'h0);
    chk({tag, "_req"},   64'(dmem_req), 64'h0);
    chk({tag, "_stall"}, 64'(mem_stall), 64'h0);
  endtask

  // Load with grant in the issue cycle and response one cycle later.
  task automatic load_fast(input string tag, input logic [2:0] f3, input logic [63:0] addr,
                           input logic [63:0] rdata, input logic [63:0] exp);
    @(negedge clk);
    drive(1'b1, 1'b0, f3, 5'd7, 1'b0, addr, 64'h0);
    dmem_gnt = 1'b1;
    #1;
    chk({tag, "_req0"},   64'(dmem_req), 64'h1);
    chk({tag, "_addr"},   dmem_addr, {addr[63:3], 3'b000});
    chk({tag, "_we"},     64'(dmem_we), 64'h0);
    chk({tag, "_stall0"}, 64'(mem_stall), 64'h1);
    sb.push_back('{bub: 1'b1, alu: 64'h0, mem: 64'h0, rd: 5'd0, full: 1'b0});
    @(negedge clk);
    check_wb({tag, "_issue"});
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = rdata;
    #1;
    chk({tag, "_stall1"}, 64'(mem_stall), 64'h0);
    chk({tag, "_req1"},   64'(dmem_req), 64'h0);
    sb.push_back('{bub: 1'b0, alu: addr, mem: exp, rd: 5'd7, full: 1'b1});
    @(negedge clk);
    dmem_rvalid = 1'b0;
    idle();
    #1;
    check_wb(tag);
    chk({tag, "_stall2"}, 64'(mem_stall), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    wb_stall    = 1'b0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = 64'h0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check_reset("rst");
    reset = 1'b0;

    // Non-memory instruction flows through in one cycle.
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd5, 1'b0, 64'h1234, 64'h0);
    sb.push_back('{bub: 1'b0, alu: 64'h1234, mem: 64'h0, rd: 5'd5, full: 1'b1});
    #1;
    chk("add_stall", 64'(mem_stall), 64'h0);
    chk("add_req",   64'(dmem_req), 64'h0);
    @(negedge clk);
    idle();
    #1;
    check_wb("add");
    chk("add_stall1", 64'(mem_stall), 64'h0);

    load_fast("lb",  3'd0, 64'h1003, 64'h00000000_80000000, 64'hFFFF_FFFF_FFFF_FF80);
    load_fast("lbu", 3'd4, 64'h1003, 64'h00000000_80000000, 64'h0000_0000_0000_0080);
    load_fast("lw",  3'd2, 64'h1004, 64'h80000000_00000000, 64'hFFFF_FFFF_8000_0000);
    load_fast("lhu", 3'd5, 64'h1006, 64'hBEEF0000_00000000, 64'h0000_0000_0000_BEEF);

    // Store with grant delayed three cycles; request fields must hold steady.
    @(negedge clk);
    drive(1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 64'h2004, 64'hDEADBEEF);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      dmem_gnt = (i == 3);
      #1;
      chk("sw_req",   64'(dmem_req), 64'h1);
      chk("sw_we",    64'(dmem_we), 64'h1);
      chk("sw_addr",  dmem_addr, 64'h2000);
      chk("sw_wdata", dmem_wdata, 64'hDEADBEEF_00000000);
      chk("sw_wstrb", 64'(dmem_wstrb), 64'hF0);
      chk("sw_stall", 64'(mem_stall), 64'h1);
      if (i > 0) chk("sw_wb_bub", 64'(wb_is_bubble), 64'h1);
    end
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    #1;
    chk("sw_ack_stall", 64'(mem_stall), 64'h0);
    chk("sw_ack_req",   64'(dmem_req), 64'h0);
    sb.push_back('{bub: 1'b0, alu: 64'h2004, mem: 64'h0, rd: 5'd0, full: 1'b1});
    @(negedge clk);
    dmem_rvalid = 1'b0;
    idle();
    #1;
    check_wb("sw");

    // Response arrives while writeback is stalled: parked in HOLD.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd3, 5'd9, 1'b0, 64'h4000, 64'h0);
    dmem_gnt = 1'b1;
    #1;
    chk("ld_req", 64'(dmem_req), 64'h1);
    @(negedge clk);
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h11223344_55667788;
    wb_stall    = 1'b1;
    #1;
    chk("ld_stall_rv", 64'(mem_stall), 64'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dmem_rvalid = 1'b0;
      dmem_rdata  = 64'hDEADDEAD_DEADDEAD;
      #1;
      chk("ld_hold_bub",   64'(wb_is_bubble), 64'h1);
      chk("ld_hold_stall", 64'(mem_stall), 64'h1);
      chk("ld_hold_req",   64'(dmem_req), 64'h0);
    end
    @(negedge clk);
    wb_stall = 1'b0;
    #1;
    chk("ld_release_stall", 64'(mem_stall), 64'h0);
    sb.push_back('{bub: 1'b0, alu: 64'h4000, mem: 64'h11223344_55667788, rd: 5'd9, full: 1'b1});
    @(negedge clk);
    idle();
    #1;
    check_wb("ld_hold");

    // Misaligned halfword: no request, no stall, bubble, sticky flag.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd1, 5'd3, 1'b0, 64'h3001, 64'h0);
    #1;
    chk("lh_mis_req",   64'(dmem_req), 64'h0);
    chk("lh_mis_stall", 64'(mem_stall), 64'h0);
    sb.push_back('{bub: 1'b1, alu: 64'h0, mem: 64'h0, rd: 5'd0, full: 1'b0});
    @(negedge clk);
    drive(1'b0, 1'b0, 3'd0, 5'd6, 1'b0, 64'h55, 64'h0);
    sb.push_back('{bub: 1'b0, alu: 64'h55, mem: 64'h0, rd: 5'd6, full: 1'b1});
    #1;
    check_wb("lh_mis");
    chk("lh_mis_flag", 64'(misaligned), 64'h1);
    @(negedge clk);
    idle();
    #1;
    check_wb("add2");
    chk("mis_sticky", 64'(misaligned), 64'h1);

    // Reset in WAIT abandons the load; the late response is ignored.
    @(negedge clk);
    drive(1'b1, 1'b0, 3'd2, 5'd4, 1'b0, 64'h5000, 64'h0);
    dmem_gnt = 1'b1;
    #1;
    chk("rw_req", 64'(dmem_req), 64'h1);
    @(negedge clk);
    dmem_gnt = 1'b0;
    reset    = 1'b1;
    idle();
    #1;
    check_reset("rw_rst");
    @(negedge clk);
    reset       = 1'b0;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 64'h0000_0000_0000_CAFE;
    #1;
    chk("rw_late_req",   64'(dmem_req), 64'h0);
    chk("rw_late_stall", 64'(mem_stall), 64'h0);
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    chk("rw_after_bub", 64'(wb_is_bubble), 64'h1);
    chk("rw_after_mem", wb_mem_result, 64'h0);
    chk("rw_after_alu", wb_alu_result, 64'h0);
    drive(1'b0, 1'b0, 3'd0, 5'd8, 1'b0, 64'h77, 64'h0);
    sb.push_back('{bub: 1'b0, alu: 64'h77, mem: 64'h0, rd: 5'd8, full: 1'b1});
    @(negedge clk);
    idle();
    #1;
    check_wb("add3");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the in-order RISC-V pipeline, between execute and writeback. Issues loads and stores to the data-memory port with a request/grant/response handshake, aligns and sign/zero-extends load data, and registers results into the MEM→WB pipeline register. It stalls upstream for the whole memory transaction and honours the writeback stall (ecall) without losing an in-flight response.

## Interface

- (no parameters; datapath fixed at 64 bits, 8 byte strobes)

- clk  in  1  pipeline clock
- reset  in  1  reset; asynchronous, active-high
- in_inst  in  decoded_inst_t  instruction from EX; uses is_load, is_store, is_ecall, rd, en_rd, funct3
- in_is_bubble  in  1  EX slot holds no instruction
- in_alu_result  in  64  ALU result / effective address
- in_store_data  in  64  rs2 value for stores
- wb_stall  in  1  writeback stall (ecall in progress)
- dmem_req  out  1  request valid
- dmem_addr  out  64  doubleword-aligned address ({addr[63:3],3'b0})
- dmem_we  out  1  1 = store
- dmem_wdata  out  64  store data shifted to byte lane
- dmem_wstrb  out  8  byte enables
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  response valid (load data or store ack)
- dmem_rdata  in  64  aligned doubleword read data
- mem_stall  out  1  hold EX→MEM register
- misaligned  out  1  sticky: misaligned access seen
- wb_inst  out  decoded_inst_t  registered instruction to WB
- wb_is_bubble  out  1  registered bubble flag
- wb_alu_result  out  64  registered ALU result
- wb_mem_result  out  64  registered extended load data (0 for stores)

## Operation

- memop = !in_is_bubble && (in_inst.is_load || in_inst.is_store). Size from funct3[1:0] (0=B,1=H,2=W,3=D); funct3[2]=1 means unsigned load (LBU/LHU/LWU).
- Misaligned: address offset addr[2:0] not a multiple of size. No request issued; set misaligned (cleared only by reset); slot goes to WB as bubble; no stall.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: if memop, aligned, !wb_stall → dmem_req=1 combinationally; gnt → WAIT, else → REQ.
  - REQ: dmem_req=1 with stable addr/we/wdata/wstrb; gnt → WAIT.
  - WAIT: rvalid && !wb_stall → complete, → IDLE; rvalid && wb_stall → capture rdata into hold register, → HOLD.
  - HOLD: !wb_stall → complete from hold register, → IDLE.
- Completion writes WB register: wb_inst=in_inst, wb_is_bubble=0, wb_alu_result=in_alu_result, wb_mem_result=extended load (0 for store).
- Load extension: byte lane = rdata >> (8*addr[2:0]); take low 8/16/32/64 bits; sign- or zero-extend per funct3[2].
- Store: wdata = in_store_data << (8*addr[2:0]); wstrb = ((1<<bytes)-1) << addr[2:0].
- mem_stall = wb_stall || (memop && aligned && !completing).
- WB register update (when !wb_stall): completing → load result; memop not completing → bubble (wb_is_bubble=1); otherwise pass in_inst/in_alu_result with wb_is_bubble=in_is_bubble, wb_mem_result=0. When wb_stall=1: WB register holds.

## Timing

- Reset (async): state IDLE, dmem_req=0, misaligned=0, wb_is_bubble=1, wb_inst/wb_alu_result/wb_mem_result=0. Reset during REQ/WAIT/HOLD abandons the transaction; later rvalid is ignored in IDLE.
- Memory guarantees rvalid no earlier than the cycle after gnt; one outstanding request.
- Minimum load latency: gnt in cycle 0 (IDLE), rvalid cycle 1, WB register valid cycle 2; mem_stall high cycle 0, low cycle 1.
- Non-memory instructions: one cycle through, no stall unless wb_stall.
- Request starts are blocked while wb_stall=1; in-flight WAIT continues.
- rvalid in IDLE/REQ: ignored.

## Test plan

- ADD, alu_result=0x1234, rd=5, no stalls → next cycle wb_alu_result=0x1234, wb_is_bubble=0, mem_stall never high.
- LB addr=0x1003, rdata=0x00000000_80000000, gnt same cycle, rvalid +1 → wb_mem_result=0xFFFF_FFFF_FFFF_FF80; LBU same → 0x80; mem_stall high exactly 1 cycle.
- SW addr=0x2004, store_data=0xDEADBEEF, gnt delayed 3 cycles → dmem_wdata=0xDEADBEEF_00000000, wstrb=0xF0 held stable across REQ; wb_mem_result=0.
- LD gnt, then wb_stall=1 when rvalid arrives with 0x1122334455667788, wb_stall drops 4 cycles later → HOLD entered, WB register unchanged during stall, then wb_mem_result=0x1122334455667788.
- LH addr=0x3001 → no dmem_req, misaligned=1, wb_is_bubble=1, no stall.
- Assert reset while in WAIT, deliver rvalid after release → all outputs at reset values, state IDLE, response ignored.
